// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard and forwarding controller for the pipelined RISC-V core. It keeps its
// own record of in-flight writers from EX (stage 0) down to stage DEPTH, and
// from that record drives the EX operand forwarding selects and the ID load-use
// stall.
// Optional feature macro: HAZARD_STATS_EN adds the stall_cnt / fwd_cnt counters.
module hazard_scoreboard_unit #(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            flush,
    output logic [SELW-1:0] fwd_a,
    output logic [SELW-1:0] fwd_b,
    output logic            stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     fwd_cnt
`endif
);

    // Per-stage producer record; index 0 is EX, index DEPTH is the last stage
    // before the register file holds the value.
    logic [DEPTH:0]  st_valid;
    logic [DEPTH:0]  st_we;
    logic [AW-1:0]   st_rd [DEPTH+1];

    // Only stages 0..DEPTH-1 take part in the stall decision, so the load flag
    // of the final stage is never needed and is not kept.
    logic [DEPTH-1:0] st_load;

    // Source operands of the instruction currently in EX.
    logic [AW-1:0]   ex_rs1;
    logic [AW-1:0]   ex_rs2;
    logic            ex_use1;
    logic            ex_use2;

    logic            capture;
    logic            hit1;
    logic            hit2;

    assign capture = !stall && !flush;

    // Shift the tracker one stage per cycle; EX takes ID or becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_we    <= '0;
            st_load  <= '0;
            for (int k = 0; k <= DEPTH; k++) begin
                st_rd[k] <= '0;
            end
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_use1 <= 1'b0;
            ex_use2 <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                st_valid[k+1] <= st_valid[k];
                st_we[k+1]    <= st_we[k];
                st_rd[k+1]    <= st_rd[k];
            end
            for (int k = 0; k < DEPTH - 1; k++) begin
                st_load[k+1] <= st_load[k];
            end
            if (capture) begin
                st_valid[0] <= id_valid;
                st_we[0]    <= id_we;
                st_rd[0]    <= id_rd;
                st_load[0]  <= id_is_load;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_use1     <= id_use_rs1 & id_valid;
                ex_use2     <= id_use_rs2 & id_valid;
            end else begin
                st_valid[0] <= 1'b0;
                st_we[0]    <= 1'b0;
                st_rd[0]    <= '0;
                st_load[0]  <= 1'b0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_use1     <= 1'b0;
                ex_use2     <= 1'b0;
            end
        end
    end

    // Forwarding select: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (st_valid[0] && ex_use1 && (ex_rs1 != '0) &&
                st_valid[k] && st_we[k] && (st_rd[k] == ex_rs1)) begin
                fwd_a = SELW'(k);
            end
            if (st_valid[0] && ex_use2 && (ex_rs2 != '0) &&
                st_valid[k] && st_we[k] && (st_rd[k] == ex_rs2)) begin
                fwd_b = SELW'(k);
            end
        end
    end

    // Load-use stall: the youngest writer of each ID source decides, so a
    // younger ALU write shadows an older load of the same register.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (st_valid[k] && st_we[k] && (st_rd[k] == id_rs1)) begin
                hit1 = st_load[k] && (k + 1 < LOAD_READY);
            end
            if (st_valid[k] && st_we[k] && (st_rd[k] == id_rs2)) begin
                hit2 = st_load[k] && (k + 1 < LOAD_READY);
            end
        end
        stall = id_valid && !flush &&
                ((id_use_rs1 && (id_rs1 != '0) && hit1) ||
                 (id_use_rs2 && (id_rs2 != '0) && hit2));
    end

`ifdef HAZARD_STATS_EN
    // Free-running wrap-around counters of stall cycles and forwarding cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((fwd_a != '0) || (fwd_b != '0)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Testbench for hazard_scoreboard_unit (DEPTH=3, LOAD_READY=2).
// Directed vector table, reset corner cases, then randomized traffic checked
// against an instruction-history reference model. Counter checks are compiled
// in when HAZARD_STATS_EN is defined.
module tb_hazard_scoreboard_unit;

    localparam int AW         = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 2;
    localparam int SELW       = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [AW-1:0]   id_rd;
    logic            id_we;
    logic            id_is_load;
    logic            flush;
    logic [SELW-1:0] fwd_a;
    logic [SELW-1:0] fwd_b;
    logic            stall;
`ifdef HAZARD_STATS_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     fwd_cnt;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(
        .AW(AW),
        .DEPTH(DEPTH),
        .LOAD_READY(LOAD_READY),
        .SELW(SELW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_valid(id_valid),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .id_rd(id_rd),
        .id_we(id_we),
        .id_is_load(id_is_load),
        .flush(flush),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b),
        .stall(stall)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .fwd_cnt(fwd_cnt)
`endif
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       we;
        logic       ld;
    } ins_t;

    typedef struct {
        string name;
        ins_t  ins;
        bit    fl;
        int    ea;
        int    eb;
        bit    es;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    // hist[n] is the instruction that entered EX n cycles ago (hist[0] is in EX now).
    ins_t hist [DEPTH+1];

    function automatic ins_t mkIns(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit we, bit ld);
        ins_t i;
        i.valid = v;
        i.rd    = 5'(rd);
        i.rs1   = 5'(rs1);
        i.rs2   = 5'(rs2);
        i.u1    = u1;
        i.u2    = u2;
        i.we    = we;
        i.ld    = ld;
        return i;
    endfunction

    function automatic ins_t alu(int rd, int rs1, int rs2);
        return mkIns(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic ins_t lw(int rd, int rs1);
        return mkIns(1'b1, rd, rs1, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic ins_t nop();
        return mkIns(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t V(string n, ins_t i, bit fl, int ea, int eb, bit es);
        vec_t v;
        v.name = n;
        v.ins  = i;
        v.fl   = fl;
        v.ea   = ea;
        v.eb   = eb;
        v.es   = es;
        return v;
    endfunction

    function automatic ins_t randIns();
        ins_t i;
        i.valid = ($urandom_range(0, 7) != 0);
        i.rd    = 5'($urandom_range(0, 3));
        i.rs1   = 5'($urandom_range(0, 3));
        i.rs2   = 5'($urandom_range(0, 3));
        i.u1    = ($urandom_range(0, 3) != 0);
        i.u2    = ($urandom_range(0, 3) != 0);
        i.ld    = ($urandom_range(0, 2) == 0);
        i.we    = i.ld || ($urandom_range(0, 3) != 0);
        return i;
    endfunction

    // The EX instruction's source r comes from the most recent earlier writer of r.
    function automatic int modelFwd(logic [4:0] r, logic u);
        if (!hist[0].valid || !u || r == 5'd0) return 0;
        for (int d = 1; d <= DEPTH; d++) begin
            if (hist[d].valid && hist[d].we && hist[d].rd == r) return d;
        end
        return 0;
    endfunction

    // A source must wait if its most recent writer is a load whose data would
    // not yet be forwardable when the consumer reaches EX next cycle.
    function automatic bit srcWaits(logic [4:0] r);
        for (int d = 0; d < DEPTH; d++) begin
            if (hist[d].valid && hist[d].we && hist[d].rd == r)
                return hist[d].ld && (d + 1 < LOAD_READY);
        end
        return 1'b0;
    endfunction

    function automatic bit modelStall(ins_t i, bit fl);
        if (!i.valid || fl) return 1'b0;
        return (i.u1 && i.rs1 != 5'd0 && srcWaits(i.rs1)) ||
               (i.u2 && i.rs2 != 5'd0 && srcWaits(i.rs2));
    endfunction

    function automatic void modelClear();
        for (int d = 0; d <= DEPTH; d++) hist[d] = nop();
    endfunction

    function automatic void modelAdvance(ins_t i, bit fl);
        bit st;
        st = modelStall(i, fl);
        for (int d = DEPTH; d >= 1; d--) hist[d] = hist[d-1];
        hist[0] = (!st && !fl && i.valid) ? i : nop();
    endfunction

    task automatic applyStimulus(input ins_t i, input bit fl);
        id_valid   = i.valid;
        id_rd      = i.rd;
        id_rs1     = i.rs1;
        id_rs2     = i.rs2;
        id_use_rs1 = i.u1;
        id_use_rs2 = i.u2;
        id_we      = i.we;
        id_is_load = i.ld;
        flush      = fl;
    endtask

    task automatic checkOutput(input string n, input int ea, input int eb, input bit es);
        tests++;
        if (fwd_a !== SELW'(ea) || fwd_b !== SELW'(eb) || stall !== es) begin
            fails++;
            $display("[TB] FAIL %s: got fwd_a=%0d fwd_b=%0d stall=%0b, expected fwd_a=%0d fwd_b=%0d stall=%0b",
                     n, fwd_a, fwd_b, stall, ea, eb, es);
        end
    endtask

    task automatic checkCount(input string n, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", n, got, want);
        end
    endtask

    // One pipeline cycle: drive ID just after the edge, sample at the falling edge.
    task automatic runCycle(input string n, input ins_t i, input bit fl,
                            input int ea, input int eb, input bit es);
        applyStimulus(i, fl);
        @(negedge clk);
        checkOutput(n, ea, eb, es);
        modelAdvance(i, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic pushDrain();
        for (int j = 0; j < 3; j++) vecs.push_back(V("drain", nop(), 1'b0, 0, 0, 1'b0));
    endtask

    initial begin
        ins_t cur;
        bit   hold;
        bit   fl;
        bit   es;
        int   ea;
        int   eb;

        rst_n = 1'b0;
        applyStimulus(nop(), 1'b0);
        modelClear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 0, 0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU back-to-back
        vecs.push_back(V("b2b_issue", alu(5, 1, 2), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("b2b_dep_id", alu(6, 5, 1), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("b2b_fwd_mem", nop(), 1'b0, 1, 0, 1'b0));
        pushDrain();
        // Distance 2
        vecs.push_back(V("dist2_issue", alu(5, 1, 2), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("dist2_gap", nop(), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("dist2_use_id", alu(7, 1, 5), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("dist2_fwd_b", nop(), 1'b0, 0, 2, 1'b0));
        pushDrain();
        // Load-use: one bubble, then forwarding from stage 2
        vecs.push_back(V("lu_load", lw(7, 1), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("lu_stall", alu(8, 7, 7), 1'b0, 0, 0, 1'b1));
        vecs.push_back(V("lu_release", alu(8, 7, 7), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("lu_fwd_wb", nop(), 1'b0, 2, 2, 1'b0));
        pushDrain();
        // Younger ALU write shadows older load
        vecs.push_back(V("shadow_load", lw(5, 1), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("shadow_alu", alu(5, 2, 3), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("shadow_use_id", alu(9, 5, 4), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("shadow_fwd", nop(), 1'b0, 1, 0, 1'b0));
        pushDrain();
        // Writes to x0 never forward or stall
        vecs.push_back(V("x0_load", lw(0, 1), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("x0_use_id", alu(10, 0, 0), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("x0_use_ex", nop(), 1'b0, 0, 0, 1'b0));
        pushDrain();
        // Unused rs2 matching a load
        vecs.push_back(V("nouse_load", lw(11, 1), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("nouse_id", mkIns(1'b1, 12, 1, 11, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("nouse_ex", nop(), 1'b0, 0, 0, 1'b0));
        pushDrain();
        // Invalid ID never stalls
        vecs.push_back(V("inval_load", lw(14, 1), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("inval_id", mkIns(1'b0, 15, 14, 14, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("inval_ex", nop(), 1'b0, 0, 0, 1'b0));
        pushDrain();
        // Flush with load in EX: no stall, load still advances
        vecs.push_back(V("flush_load", lw(3, 1), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("flush_cycle", alu(4, 3, 3), 1'b1, 0, 0, 1'b0));
        vecs.push_back(V("flush_bubble", mkIns(1'b1, 13, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 0, 0, 1'b0));
        vecs.push_back(V("flush_load_kept", nop(), 1'b0, 2, 0, 1'b0));
        pushDrain();

        foreach (vecs[n]) begin
            runCycle(vecs[n].name, vecs[n].ins, vecs[n].fl, vecs[n].ea, vecs[n].eb, vecs[n].es);
        end

        // Reset in the middle of a stall while a forward is active
        runCycle("rst_seq_alu", alu(5, 1, 2), 1'b0, 0, 0, 1'b0);
        runCycle("rst_seq_load", lw(7, 5), 1'b0, 0, 0, 1'b0);
        applyStimulus(alu(8, 7, 7), 1'b0);
        @(negedge clk);
        checkOutput("rst_seq_stall", 1, 0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_drop", 0, 0, 1'b0);
        modelClear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runCycle("after_reset_id", alu(8, 7, 7), 1'b0, 0, 0, 1'b0);
        runCycle("after_reset_ex", nop(), 1'b0, 0, 0, 1'b0);
        for (int j = 0; j < 3; j++) runCycle("drain", nop(), 1'b0, 0, 0, 1'b0);

        // Randomized traffic against the history model
        hold = 1'b0;
        cur  = nop();
        for (int n = 0; n < 400; n++) begin
            if (!hold) cur = randIns();
            fl = ($urandom_range(0, 9) == 0);
            es = modelStall(cur, fl);
            ea = modelFwd(hist[0].rs1, hist[0].u1);
            eb = modelFwd(hist[0].rs2, hist[0].u2);
            runCycle("random", cur, fl, ea, eb, es);
            hold = es;
        end

`ifdef HAZARD_STATS_EN
        // Three load-use pairs from a clean reset
        applyStimulus(nop(), 1'b0);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelClear();
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            runCycle("stats_load", lw(7, 1), 1'b0, 0, 0, 1'b0);
            runCycle("stats_stall", alu(8, 7, 7), 1'b0, 0, 0, 1'b1);
            runCycle("stats_release", alu(8, 7, 7), 1'b0, 0, 0, 1'b0);
            runCycle("stats_fwd", nop(), 1'b0, 2, 2, 1'b0);
            for (int j = 0; j < 3; j++) runCycle("stats_drain", nop(), 1'b0, 0, 0, 1'b0);
        end
        @(negedge clk);
        checkCount("stall_cnt", stall_cnt, 32'd3);
        checkCount("fwd_cnt", fwd_cnt, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
